// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_sb register file.
//   DEFAULT_DATA_W / DEFAULT_NREGS : default geometry
//   word_t / raddr_t               : default-geometry word and address types
//   wide_t / wide_be_t             : widest supported word and byte-enable vectors
//   byte_merge()                   : applies a byte-enabled write to an old word
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_NREGS  = 16;

  // byte_merge works on the widest supported word so that every
  // parameterisation can share it. Callers zero-extend on the way in and
  // slice on the way out.
  localparam int MAX_DATA_W = 512;
  localparam int MAX_BYTES  = MAX_DATA_W / 8;

  typedef logic [DEFAULT_DATA_W-1:0]         word_t;
  typedef logic [$clog2(DEFAULT_NREGS)-1:0]  raddr_t;
  typedef logic [MAX_DATA_W-1:0]             wide_t;
  typedef logic [MAX_BYTES-1:0]              wide_be_t;

  // Byte i of the result comes from new_w when be[i] is set, else from old_w.
  function automatic wide_t byte_merge(input wide_t old_w, input wide_t new_w,
                                       input wide_be_t be);
    wide_t r;
    r = old_w;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard.
//   clk, rst            : clock, synchronous active-high reset
//   we3, a3             : write-back enable/address (clears busy)
//   iss_valid, iss_addr : issue enable/destination (sets busy)
//   a1, a2              : lookup addresses
//   busy1, busy2        : lookup results with same-cycle clear bypass
//   busy_vec            : registered scoreboard
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a3,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic              busy1,
  output logic              busy2,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_nxt;
  logic             wb_clears;

  // A write-back only retires the pending write if the same edge does not
  // issue a newer write to that register.
  assign wb_clears = we3 && !(iss_valid && (iss_addr == a3));

  always_comb begin
    // NOTE: default first, then ordered overrides; blocking assignments make
    // the later set take priority over the earlier clear and avoid a latch.
    busy_nxt = busy_vec;
    if (we3)       busy_nxt[a3]       = 1'b0;
    if (iss_valid) busy_nxt[iss_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0]    = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_vec <= '0;
    else     busy_vec <= busy_nxt;
  end

  assign busy1 = busy_vec[a1] && !(wb_clears && (a1 == a3));
  assign busy2 = busy_vec[a2] && !(wb_clears && (a2 == a3));

endmodule

// File: rtl/regfile_sb.sv
// 2-read / 1-write register file with byte enables, write-to-read bypass,
// optional hardwired zero register and busy scoreboard.
//   clk, rst             : clock, synchronous active-high clear
//   we3, a3, wd3, be3    : write-back port (byte-enabled)
//   a1/rd1, a2/rd2       : combinational read ports, bypassing the write port
//   busy1, busy2         : pending-write flags for a1/a2
//   iss_valid, iss_addr  : issue stage marks a destination busy
//   busy_vec             : registered scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int ZERO_REG = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we3,
  input  logic [ADDR_W-1:0]   a3,
  input  logic [DATA_W-1:0]   wd3,
  input  logic [DATA_W/8-1:0] be3,
  input  logic [ADDR_W-1:0]   a1,
  input  logic [ADDR_W-1:0]   a2,
  output logic [DATA_W-1:0]   rd1,
  output logic [DATA_W-1:0]   rd2,
  output logic                busy1,
  output logic                busy2,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_addr,
  output logic [NREGS-1:0]    busy_vec
);

  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] wr_merged;
  logic              wr_en;

  // Value register a3 will hold after this edge; feeds both storage and bypass.
  always_comb begin
    wide_t    old_w;
    wide_t    new_w;
    wide_t    mrg_w;
    wide_be_t be_w;
    old_w = '0;
    new_w = '0;
    be_w  = '0;
    old_w[DATA_W-1:0] = regs[a3];
    new_w[DATA_W-1:0] = wd3;
    be_w[NBYTES-1:0]  = be3;
    mrg_w     = byte_merge(old_w, new_w, be_w);
    wr_merged = mrg_w[DATA_W-1:0];
  end

  assign wr_en = we3 && !((ZERO_REG != 0) && (a3 == '0));

  // NOTE: the storage array is cleared by rst, so it maps to flops rather
  // than a RAM macro; the synchronous clear is a functional requirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[a3] <= wr_merged;
    end
  end

  always_comb begin
    rd1 = regs[a1];
    if (we3 && (a1 == a3))                 rd1 = wr_merged;
    if ((ZERO_REG != 0) && (a1 == '0))     rd1 = '0;
    rd2 = regs[a2];
    if (we3 && (a2 == a3))                 rd2 = wr_merged;
    if ((ZERO_REG != 0) && (a2 == '0))     rd2 = '0;
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .we3       (we3),
    .a3        (a3),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .a1        (a1),
    .a2        (a2),
    .busy1     (busy1),
    .busy2     (busy2),
    .busy_vec  (busy_vec)
  );

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised 2-read / 1-write register file for the datapath. Successor to the fixed 16x32 register file. Adds:
- synchronous clear
- byte-enabled writes
- same-cycle write-to-read bypass
- optional hardwired zero register
- per-register busy scoreboard so the issue stage can detect pending write-backs

Sits between decode (read/issue) and write-back.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8
NREGS, 16, number of registers; power of two, >= 2
ADDR_W, $clog2(NREGS), address width; derived, do not override
ZERO_REG, 0, 1 = register 0 reads as 0, ignores writes and never goes busy

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
we3  in  1  write-back enable
a3  in  ADDR_W  write-back address
wd3  in  DATA_W  write-back data
be3  in  DATA_W/8  byte enables; bit i covers wd3[8i+7:8i]
a1  in  ADDR_W  read port 1 address
a2  in  ADDR_W  read port 2 address
rd1  out  DATA_W  read port 1 data (combinational)
rd2  out  DATA_W  read port 2 data (combinational)
busy1  out  1  register a1 has a pending write (combinational)
busy2  out  1  register a2 has a pending write (combinational)
iss_valid  in  1  issue marks register iss_addr busy
iss_addr  in  ADDR_W  destination register of issued instruction
busy_vec  out  NREGS  full scoreboard, registered

Behaviour:
Reset
- rst sampled high at a clock edge: every register := 0 and busy_vec := 0.
- rst overrides we3 and iss_valid in that cycle.
- rd1/rd2 read 0 and busy1/busy2 read 0 from the first cycle after reset.
- Reset mid-operation drops all pending busy bits.

Write
- On the clock edge with we3=1: regfile[a3] byte i := wd3 byte i for each be3[i]=1; other bytes are held.
- we3=1 with be3=0 changes no data but still performs the busy clear below.

Read
- Combinational; zero-cycle latency from a1/a2.
- Bypass: if we3=1 and a1==a3, rd1 = merge(regfile[a3], wd3, be3), i.e. the value the register will hold after the edge. Same rule for rd2.
- Both ports may address the same register.
- With ZERO_REG=1, a read of address 0 returns 0 regardless of bypass.

Scoreboard
- Write-back with we3=1 clears busy[a3] at the edge.
- iss_valid=1 sets busy[iss_addr] at the edge.
- Same edge, iss_addr==a3: the set wins; busy stays 1, since a newer write is now pending.
- Issue to an already-busy register: stays 1. Single-bit scoreboard; the issue stage must stall on busy before re-issuing the same destination.
- Write-back to a non-busy register: data written, busy stays 0.
- busy1/busy2 = busy_vec[a1]/busy_vec[a2] with clear-bypass: if we3=1, a1==a3 and not (iss_valid and iss_addr==a3), busy1=0 in the same cycle.
- With ZERO_REG=1: busy[0] is held at 0 and writes to register 0 are discarded.

Out-of-range addresses are impossible because NREGS is a power of two.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W / NREGS constants
  - typedef word_t (logic [DATA_W-1:0])
  - typedef raddr_t
  - function byte_merge(old, new, be), shared by the write path and the bypass path
- One sub-module, regfile_scoreboard: the busy vector with set/clear priority, plus the busy1/busy2 lookup with clear-bypass.
- Storage, byte merge and read muxes stay in regfile_sb.

Test Plan:
1. Reset, then a1=5, a2=15 -> rd1=rd2=0, busy_vec=0. Then hold we3=1, be3=F, wd3=0xDEADBEEF, a3=3 with rst=1 -> after the edge reg3 still reads 0.
2. Write a3=7, wd3=0x11223344, be3=F; next cycle a3=7, wd3=0xAABBCCDD, be3=0101b -> reg7 = 0x11BB33DD after the second edge. Before that edge, a1=7 bypass shows 0x11BB33DD in the same cycle.
3. Bypass on both ports: we3=1, a3=a1=a2=9, wd3=0xCAFEF00D, be3=F -> rd1=rd2=0xCAFEF00D before the edge; the old value appears only if we3=0.
4. Scoreboard:
   - iss_valid, iss_addr=4 -> busy_vec[4]=1 next cycle, busy1=1 with a1=4.
   - we3=1, a3=4 -> busy1=0 combinationally; busy_vec[4]=0 after the edge.
   - Repeat with iss_valid, iss_addr=4 in the same cycle as we3, a3=4 -> busy_vec[4] stays 1 and busy1 stays 1.
5. ZERO_REG=1 build: we3=1, a3=0, wd3=0xFFFFFFFF and iss_valid, iss_addr=0 -> rd1(a1=0)=0 before and after the edge, busy_vec[0]=0.
6. Mid-operation reset: busy_vec=0x00F0 with reg2=0x55 -> rst one cycle -> busy_vec=0 and rd1(a1=2)=0. Parameter sweep DATA_W=64, NREGS=32 repeats scenarios 2 and 4.
